regfile_mp: RTL and testbench

Parametrised multi-read-port register file with byte-enabled write, same-cycle write bypass and a per-register pending-write scoreboard. It replaces the fixed 3-read/1-write 32x32 register file in the pipelined MIPS datapath. Decode reads operands and hazard status from it. Issue reserves destinations, and writeback retires them.

---
 rtl/regfile_mp.sv | 93 +++++++++
 tb/tb_regfile_mp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled write and a pending-write scoreboard.
// Define REGFILE_MP_BYPASS_EN to forward a same-cycle write to matching read ports.
module regfile_mp #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 5,
    parameter int          NUM_RD  = 3,
    parameter int          SP_IDX  = 29,
    parameter logic [31:0] SP_INIT = 32'h100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [DATA_W/8-1:0]      wbe,
    input  logic                     rsv,
    input  logic [ADDR_W-1:0]        rsv_a,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        busy,
    output logic                     any_busy
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam int                NBYTES = DATA_W / 8;
    localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic              wr_en;
    logic              rsv_en;

    assign wr_en  = we && (wa != '0);
    assign rsv_en = rsv && (rsv_a != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == SP_IDX) ? SP_VAL : '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wbe[b]) begin
                    mem[wa][b*8 +: 8] <= wd[b*8 +: 8];
                end
            end
        end
    end

    // The reserve is scheduled after the clear so a same-register reserve wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            if (wr_en) begin
                pend[wa] <= 1'b0;
            end
            if (rsv_en) begin
                pend[rsv_a] <= 1'b1;
            end
        end
    end

    assign any_busy = |pend;

`ifdef REGFILE_MP_BYPASS_EN
    logic [DATA_W-1:0] merged;

    always_comb begin
        merged = mem[wa];
        for (int b = 0; b < NBYTES; b++) begin
            if (wbe[b]) begin
                merged[b*8 +: 8] = wd[b*8 +: 8];
            end
        end
    end
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] word;

        assign addr = ra[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_MP_BYPASS_EN
        assign word = (wr_en && !rst && (addr == wa)) ? merged : mem[addr];
`else
        assign word = mem[addr];
`endif
        assign rd[k*DATA_W +: DATA_W] = (addr == '0) ? '0 : word;
        assign busy[k]                = pend[addr];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp against an array/bit-vector model of the register file.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 3;
    localparam int DEPTH = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           we;
    logic [AW-1:0]  wa;
    logic [DW-1:0]  wd;
    logic [3:0]     wbe;
    logic           rsv;
    logic [AW-1:0]  rsv_a;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]  busy;
    logic           any_busy;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] m_mem  [DEPTH];
    bit          m_pend [DEPTH];

    regfile_mp dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
        .rsv(rsv), .rsv_a(rsv_a), .ra(ra), .rd(rd), .busy(busy), .any_busy(any_busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_mem[29] = 32'h100;
    endtask

    task automatic model_edge();
        if (we && wa != 0) begin
            for (int b = 0; b < 4; b++)
                if (wbe[b]) m_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
            m_pend[wa] = 1'b0;
        end
        if (rsv && rsv_a != 0) m_pend[rsv_a] = 1'b1;
    endtask

    function automatic logic [31:0] exp_rd(int k);
        logic [AW-1:0] a;
        logic [31:0]   v;
        a = ra[k*AW +: AW];
        if (a == 0) return 32'h0;
        v = m_mem[a];
`ifdef REGFILE_MP_BYPASS_EN
        if (!rst && we && wa == a)
            for (int b = 0; b < 4; b++)
                if (wbe[b]) v[b*8 +: 8] = wd[b*8 +: 8];
`endif
        return v;
    endfunction

    function automatic bit exp_any();
        bit r = 1'b0;
        for (int i = 0; i < DEPTH; i++) r |= m_pend[i];
        return r;
    endfunction

    task automatic check_all(string tag);
        for (int k = 0; k < NR; k++) begin
            vectors++;
            if (rd[k*DW +: DW] !== exp_rd(k)) begin
                errors++;
                $display("FAIL %s rd[%0d] got %h want %h", tag, k, rd[k*DW +: DW], exp_rd(k));
            end
            vectors++;
            if (busy[k] !== m_pend[ra[k*AW +: AW]]) begin
                errors++;
                $display("FAIL %s busy[%0d] got %b want %b", tag, k, busy[k], m_pend[ra[k*AW +: AW]]);
            end
        end
        vectors++;
        if (any_busy !== exp_any()) begin
            errors++;
            $display("FAIL %s any_busy got %b want %b", tag, any_busy, exp_any());
        end
    endtask

    task automatic expect_lit(string name, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Entered at posedge+1: check mid-cycle, then advance the model on the edge.
    task automatic cycle(string tag);
        #3;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        we = 1'b0; wa = '0; wd = '0; wbe = '0; rsv = 1'b0; rsv_a = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        ra = {a2, a1, a0};
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; wa = a; wd = d; wbe = be;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        set_idle();
        rst = 1'b0;
        set_ra(29, 29, 29);
        #2 rst = 1'b1;
        #1 model_reset();
        expect_lit("reset_rd0_sp", rd[0 +: DW], 32'h100);
        expect_lit("reset_rd2_sp", rd[2*DW +: DW], 32'h100);
        expect_lit("reset_busy", {29'h0, busy}, 32'h0);
        set_ra(5, 29, 0);
        #1;
        expect_lit("reset_rd0_r5", rd[0 +: DW], 32'h0);
        check_all("reset");
        release_reset();

        do_write(8, 32'hAABBCCDD, 4'hF);
        cycle("wr8a");
        do_write(8, 32'h11223344, 4'b0101);
        cycle("wr8b");
        set_idle();
        set_ra(8, 8, 8);
        #1 expect_lit("byte_enable_r8", rd[0 +: DW], 32'hAA22CC44);
        cycle("rd8");

        do_write(3, 32'h1111, 4'hF);
        cycle("wr3a");
        do_write(3, 32'h5A5A, 4'hF);
        set_ra(3, 0, 8);
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        expect_lit("bypass_same_cycle", rd[0 +: DW], 32'h5A5A);
`else
        expect_lit("nobypass_old", rd[0 +: DW], 32'h1111);
`endif
        cycle("wr3b");
        set_idle();
        #1 expect_lit("r3_next_cycle", rd[0 +: DW], 32'h5A5A);
        cycle("rd3");

        do_write(0, 32'hFFFFFFFF, 4'hF);
        rsv = 1'b1; rsv_a = 0;
        set_ra(0, 0, 0);
        #1 expect_lit("r0_same_cycle", rd[0 +: DW], 32'h0);
        cycle("r0wr");
        set_idle();
        #1;
        expect_lit("r0_read", rd[0 +: DW], 32'h0);
        expect_lit("r0_busy", {31'h0, busy[0]}, 32'h0);
        expect_lit("r0_any_busy", {31'h0, any_busy}, 32'h0);
        cycle("r0chk");

        rsv = 1'b1; rsv_a = 7;
        set_ra(7, 3, 7);
        #1 expect_lit("rsv7_same_cycle", {31'h0, busy[0]}, 32'h0);
        cycle("rsv7");
        set_idle();
        #1 expect_lit("rsv7_next", {31'h0, busy[0]}, 32'h1);
        do_write(7, 32'hDEAD, 4'hF);
        rsv = 1'b1; rsv_a = 7;
        cycle("wr_rsv7");
        set_idle();
        #1 expect_lit("rsv_wins", {31'h0, busy[0]}, 32'h1);
        do_write(7, 32'hBEEF, 4'h0);
        cycle("wr7");
        set_idle();
        #1;
        expect_lit("clear7_busy", {31'h0, busy[0]}, 32'h0);
        expect_lit("clear7_any", {31'h0, any_busy}, 32'h0);
        cycle("clr7");

        rsv = 1'b1; rsv_a = 4;
        cycle("rsv4");
        rsv = 1'b1; rsv_a = 9;
        do_write(12, 32'h77, 4'hF);
        cycle("rsv9wr12");
        set_idle();
        set_ra(4, 9, 12);
        #1;
        expect_lit("pre_rst_busy", {29'h0, busy}, 32'h3);
        expect_lit("pre_rst_r12", rd[2*DW +: DW], 32'h77);
        #1 rst = 1'b1;
        #1 model_reset();
        expect_lit("mid_rst_busy", {29'h0, busy}, 32'h0);
        expect_lit("mid_rst_any", {31'h0, any_busy}, 32'h0);
        expect_lit("mid_rst_r12", rd[2*DW +: DW], 32'h0);
        set_ra(29, 9, 12);
        #1 expect_lit("mid_rst_r29", rd[0 +: DW], 32'h100);
        check_all("mid_rst");
        release_reset();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                set_idle();
                #2 rst = 1'b1;
                #1 model_reset();
                check_all("rnd_rst");
                release_reset();
                continue;
            end
            we    = ($urandom_range(0, 2) != 0);
            wa    = rnd_addr();
            wd    = $urandom();
            wbe   = 4'($urandom_range(0, 15));
            rsv   = ($urandom_range(0, 2) == 0);
            rsv_a = rnd_addr();
            set_ra(rnd_addr(), ($urandom_range(0, 3) == 0) ? wa : rnd_addr(), rnd_addr());
            cycle("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
